// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types and helpers for the icache refill path.
//   - refill_state_e : refill FSM states (idle, request, burst, return)
//   - refill_req_t   : latched icache request (physical address, non-cacheable flag, TID)
//   - num_words()    : number of AXI beats per cache line
//   - blen_width()   : width of the burst-length / beat-counter field (at least 1 bit)
// The struct fields are sized by RefillPlenWidth / RefillIdWidth; the assembler's
// PlenWidth / IdWidth parameters default to these and must match them.
package wt_cache_pkg;

    localparam int unsigned IcacheLineWidth = 128;
    localparam int unsigned RefillPlenWidth = 56;
    localparam int unsigned RefillIdWidth   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBurst,
        StRtrn
    } refill_state_e;

    typedef struct packed {
        logic [RefillPlenWidth-1:0] paddr;
        logic                       nc;
        logic [RefillIdWidth-1:0]   tid;
    } refill_req_t;

    function automatic int unsigned num_words(input int unsigned line_width,
                                              input int unsigned data_width);
        return line_width / data_width;
    endfunction

    function automatic int unsigned blen_width(input int unsigned n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_linebuf.sv
// icache_refill_linebuf: cache-line assembly register.
// Each write stores one beat into word[cnt] and advances cnt, which saturates at
// NumWords-1. clear_i zeroes every word and the counter, so words not written by a
// short burst read back as zero.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clear_i    zero the line and the counter (new request accepted)
//   wr_en_i    write wr_data_i into the current word
//   wr_data_i  beat data
//   line_o     assembled line, word 0 in the least significant bits
module icache_refill_linebuf #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumWords  = 2,
    parameter int unsigned BlenWidth = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          wr_en_i,
    input  logic [DataWidth-1:0]          wr_data_i,
    output logic [NumWords*DataWidth-1:0] line_o
);

    localparam logic [BlenWidth-1:0] CntMax = BlenWidth'(NumWords - 1);

    logic [DataWidth-1:0] words_q [NumWords];
    logic [DataWidth-1:0] words_d [NumWords];
    logic [BlenWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        words_d = words_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            for (int i = 0; i < int'(NumWords); i++) begin
                words_d[i] = '0;
            end
            cnt_d = '0;
        end else if (wr_en_i) begin
            words_d[cnt_q] = wr_data_i;
            // Saturate so extra beats keep overwriting the last word instead of wrapping.
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumWords); i++) begin
                words_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            words_q <= words_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        line_o = '0;
        for (int i = 0; i < int'(NumWords); i++) begin
            line_o[i*DataWidth +: DataWidth] = words_q[i];
        end
    end

endmodule

// File: rtl/icache_refill_assembler.sv
// icache_refill_assembler: refill stage between the L1 icache memory interface and the
// AXI shim read port. Accepts one request at a time, holds the read request until
// granted, assembles the returned beats into a line and returns it as a one-cycle pulse.
// Optional feature macro: ICACHE_REFILL_ERR_CHECK_EN adds the sticky err_o flag and
// suppresses lines whose burst saw a non-okay beat or a mismatched-ID beat.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   kill the in-flight refill (its return is suppressed)
//   req_valid_i/paddr/nc/tid  icache request; req_ack_o acknowledges it (IDLE only)
//   rd_req_o/rd_gnt_i         AXI shim read request handshake
//   rd_addr_o/blen/size/id    read request fields, valid while rd_req_o is high
//   rd_valid_i/last/data/id   read beats; rd_exokay_i is used for error checking only
//   rtrn_vld_o/data/tid       line return pulse
//   busy_o                    refill in progress
//   err_o                     sticky error flag (macro builds only)
module icache_refill_assembler
    import wt_cache_pkg::*;
#(
    parameter int unsigned LineWidth = IcacheLineWidth,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned PlenWidth = RefillPlenWidth,
    parameter int unsigned IdWidth   = RefillIdWidth,
    parameter int unsigned NumWords  = num_words(LineWidth, DataWidth),
    parameter int unsigned BlenWidth = blen_width(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    input  logic [PlenWidth-1:0] req_paddr_i,
    input  logic                 req_nc_i,
    input  logic [IdWidth-1:0]   req_tid_i,
    output logic                 req_ack_o,
    output logic                 rd_req_o,
    input  logic                 rd_gnt_i,
    output logic [63:0]          rd_addr_o,
    output logic [BlenWidth-1:0] rd_blen_o,
    output logic [1:0]           rd_size_o,
    output logic [IdWidth-1:0]   rd_id_o,
    input  logic                 rd_valid_i,
    input  logic                 rd_last_i,
    input  logic [DataWidth-1:0] rd_data_i,
    input  logic [IdWidth-1:0]   rd_id_i,
    input  logic                 rd_exokay_i,
    output logic                 rtrn_vld_o,
    output logic [LineWidth-1:0] rtrn_data_o,
    output logic [IdWidth-1:0]   rtrn_tid_o,
    output logic                 busy_o
`ifdef ICACHE_REFILL_ERR_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    // Byte-offset bits of a line; cleared for cacheable requests.
    localparam int unsigned OffsetWidth = $clog2(LineWidth / 8);

    refill_state_e state_q, state_d;
    refill_req_t   req_q, req_d;
    logic          kill_q, kill_d;
    logic          buf_clear, buf_wr;
    logic          id_match, beat_ok;
    logic [PlenWidth-1:0] line_paddr;

    assign id_match = (rd_id_i == req_q.tid);
    assign beat_ok  = (state_q == StBurst) && rd_valid_i && id_match;

`ifdef ICACHE_REFILL_ERR_CHECK_EN
    logic err_q, err_d;
    logic line_err_q, line_err_d;
    logic beat_err;

    // The lock bit is never set on this path, so any non-okay accepted beat is an error.
    assign beat_err   = (state_q == StBurst) &&
                        ((beat_ok && !rd_exokay_i) || (rd_valid_i && !id_match));
    assign line_err_d = req_ack_o ? 1'b0 : (line_err_q | beat_err);
    assign err_d      = err_q | beat_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            line_err_q <= line_err_d;
        end
    end

    assign err_o = err_q;
`else
    logic line_err_d;
    logic unused_exokay;

    assign line_err_d    = 1'b0;
    assign unused_exokay = rd_exokay_i;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        kill_d    = kill_q;
        buf_clear = 1'b0;
        buf_wr    = 1'b0;
        req_ack_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && !rst_i) begin
                    req_ack_o   = 1'b1;
                    req_d.paddr = req_paddr_i;
                    req_d.nc    = req_nc_i;
                    req_d.tid   = req_tid_i;
                    buf_clear   = 1'b1;
                    kill_d      = 1'b0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // The request stays up even when killed; the burst is drained and dropped.
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (rd_gnt_i) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                kill_d = kill_q | flush_i;
                buf_wr = beat_ok;
                if (beat_ok && rd_last_i) begin
                    state_d = (kill_d || line_err_d) ? StIdle : StRtrn;
                end
            end
            StRtrn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            req_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            kill_q  <= kill_d;
        end
    end

    icache_refill_linebuf #(
        .DataWidth(DataWidth),
        .NumWords (NumWords),
        .BlenWidth(BlenWidth)
    ) u_linebuf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (buf_clear),
        .wr_en_i  (buf_wr),
        .wr_data_i(rd_data_i),
        .line_o   (rtrn_data_o)
    );

    assign line_paddr = {req_q.paddr[PlenWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};

    // Request fields are driven only while the request is up, so they read zero otherwise.
    always_comb begin
        rd_addr_o = '0;
        rd_blen_o = '0;
        rd_size_o = 2'b00;
        rd_id_o   = '0;
        if (state_q == StReq) begin
            rd_addr_o = 64'(req_q.nc ? req_q.paddr : line_paddr);
            rd_blen_o = req_q.nc ? '0 : BlenWidth'(NumWords - 1);
            rd_size_o = 2'b11;
            rd_id_o   = req_q.tid;
        end
    end

    assign rd_req_o   = (state_q == StReq);
    assign rtrn_vld_o = (state_q == StRtrn);
    assign rtrn_tid_o = req_q.tid;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_icache_refill_assembler.sv
// Scoreboard bench for icache_refill_assembler: stimulus pushes expected read requests and
// line returns into queues; a negedge monitor compares whatever the DUT presents.
module tb_icache_refill_assembler;

    logic         clk = 1'b0;
    logic         rst_i, flush_i;
    logic         req_valid_i, req_nc_i, req_ack_o;
    logic [55:0]  req_paddr_i;
    logic [3:0]   req_tid_i;
    logic         rd_req_o, rd_gnt_i;
    logic [63:0]  rd_addr_o;
    logic [0:0]   rd_blen_o;
    logic [1:0]   rd_size_o;
    logic [3:0]   rd_id_o;
    logic         rd_valid_i, rd_last_i, rd_exokay_i;
    logic [63:0]  rd_data_i;
    logic [3:0]   rd_id_i;
    logic         rtrn_vld_o, busy_o;
    logic [127:0] rtrn_data_o;
    logic [3:0]   rtrn_tid_o;
`ifdef ICACHE_REFILL_ERR_CHECK_EN
    logic         err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic [0:0]  blen;
        logic [3:0]  id;
    } rd_exp_t;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tid;
    } rtrn_exp_t;

    rd_exp_t   exp_rd[$];
    rtrn_exp_t exp_rtrn[$];

    icache_refill_assembler dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .req_valid_i(req_valid_i),
        .req_paddr_i(req_paddr_i),
        .req_nc_i   (req_nc_i),
        .req_tid_i  (req_tid_i),
        .req_ack_o  (req_ack_o),
        .rd_req_o   (rd_req_o),
        .rd_gnt_i   (rd_gnt_i),
        .rd_addr_o  (rd_addr_o),
        .rd_blen_o  (rd_blen_o),
        .rd_size_o  (rd_size_o),
        .rd_id_o    (rd_id_o),
        .rd_valid_i (rd_valid_i),
        .rd_last_i  (rd_last_i),
        .rd_data_i  (rd_data_i),
        .rd_id_i    (rd_id_i),
        .rd_exokay_i(rd_exokay_i),
        .rtrn_vld_o (rtrn_vld_o),
        .rtrn_data_o(rtrn_data_o),
        .rtrn_tid_o (rtrn_tid_o),
        .busy_o     (busy_o)
`ifdef ICACHE_REFILL_ERR_CHECK_EN
        ,
        .err_o      (err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares the request fields every cycle the request is up, pops on grant.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rd_req_o) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_rd_req", 128'(rd_addr_o), 128'(0));
                end else begin
                    chk("rd_addr", 128'(rd_addr_o), 128'(exp_rd[0].addr));
                    chk("rd_blen", 128'(rd_blen_o), 128'(exp_rd[0].blen));
                    chk("rd_id",   128'(rd_id_o),   128'(exp_rd[0].id));
                    chk("rd_size", 128'(rd_size_o), 128'(2'b11));
                    if (rd_gnt_i) void'(exp_rd.pop_front());
                end
            end
            if (rtrn_vld_o) begin
                if (exp_rtrn.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rtrn: got data %0h tid %0h expected no return",
                             rtrn_data_o, rtrn_tid_o);
                end else begin
                    chk("rtrn_data", rtrn_data_o, exp_rtrn[0].data);
                    chk("rtrn_tid", 128'(rtrn_tid_o), 128'(exp_rtrn[0].tid));
                    void'(exp_rtrn.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [55:0] paddr, input logic nc, input logic [3:0] tid,
                          input bit hold);
        bit acked = 0;
        req_paddr_i = paddr;
        req_nc_i    = nc;
        req_tid_i   = tid;
        req_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ack_o) begin
                acked = 1;
                break;
            end
        end
        if (!acked) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_ack_timeout: got no ack expected ack within 20 cycles");
        end
        step();
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic grant(input int delay);
        repeat (delay) step();
        rd_gnt_i = 1'b1;
        step();
        rd_gnt_i = 1'b0;
    endtask

    task automatic beat(input logic [63:0] data, input logic [3:0] id, input logic last);
        rd_valid_i  = 1'b1;
        rd_data_i   = data;
        rd_id_i     = id;
        rd_last_i   = last;
        rd_exokay_i = 1'b1;
        step();
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
    endtask

    int rtrn_cyc;
    int ack_cyc;

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b1;
        req_paddr_i = '0;
        req_nc_i    = 1'b0;
        req_tid_i   = '0;
        rd_gnt_i    = 1'b0;
        rd_valid_i  = 1'b0;
        rd_last_i   = 1'b0;
        rd_data_i   = '0;
        rd_id_i     = '0;
        rd_exokay_i = 1'b1;

        // Reset: ack forced low even with a valid request, all outputs zero.
        step();
        step();
        @(negedge clk);
        chk("reset_ack", 128'(req_ack_o), 128'(0));
        chk("reset_busy", 128'(busy_o), 128'(0));
        chk("reset_rd_req", 128'(rd_req_o), 128'(0));
        chk("reset_rtrn_vld", 128'(rtrn_vld_o), 128'(0));
        chk("reset_rtrn_data", rtrn_data_o, 128'(0));
`ifdef ICACHE_REFILL_ERR_CHECK_EN
        chk("reset_err", 128'(err_o), 128'(0));
`endif
        req_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();

        // Cacheable refill, grant after 2 cycles.
        exp_rd.push_back('{addr: 64'h8000_1230, blen: 1'b1, id: 4'd3});
        exp_rtrn.push_back('{data: {64'hB, 64'hA}, tid: 4'd3});
        do_req(56'h8000_1238, 1'b0, 4'd3, 1'b0);
        grant(2);
        beat(64'hA, 4'd3, 1'b0);
        beat(64'hB, 4'd3, 1'b1);
        repeat (2) step();

        // Non-cacheable single beat; word 1 stays zero.
        exp_rd.push_back('{addr: 64'h1000_0004, blen: 1'b0, id: 4'd1});
        exp_rtrn.push_back('{data: {64'h0, 64'hDEAD}, tid: 4'd1});
        do_req(56'h1000_0004, 1'b1, 4'd1, 1'b0);
        grant(0);
        beat(64'hDEAD, 4'd1, 1'b1);
        repeat (2) step();

        // ID filter: stray beat with id 5 is ignored.
        exp_rd.push_back('{addr: 64'h8000_2000, blen: 1'b1, id: 4'd3});
`ifndef ICACHE_REFILL_ERR_CHECK_EN
        exp_rtrn.push_back('{data: {64'h22, 64'h11}, tid: 4'd3});
`endif
        do_req(56'h8000_2008, 1'b0, 4'd3, 1'b0);
        grant(0);
        beat(64'h55, 4'd5, 1'b0);
        beat(64'h11, 4'd3, 1'b0);
        beat(64'h22, 4'd3, 1'b1);
        step();
`ifdef ICACHE_REFILL_ERR_CHECK_EN
        @(negedge clk);
        chk("err_sticky", 128'(err_o), 128'(1));
`endif
        step();

        // Flush during REQ: burst completes, no return, next request acked right away.
        exp_rd.push_back('{addr: 64'h8000_3000, blen: 1'b1, id: 4'd6});
        do_req(56'h8000_3000, 1'b0, 4'd6, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        grant(1);
        beat(64'h1, 4'd6, 1'b0);
        beat(64'h2, 4'd6, 1'b1);
        exp_rd.push_back('{addr: 64'h2000_0040, blen: 1'b1, id: 4'd2});
        req_paddr_i = 56'h2000_0048;
        req_nc_i    = 1'b0;
        req_tid_i   = 4'd2;
        req_valid_i = 1'b1;
        @(negedge clk);
        chk("flush_busy_dropped", 128'(busy_o), 128'(0));
        chk("flush_next_ack", 128'(req_ack_o), 128'(1));
        step();
        req_valid_i = 1'b0;

        // Reset after the first beat, then a late last beat: dropped, all outputs zero.
        grant(0);
        beat(64'h77, 4'd2, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        beat(64'h88, 4'd2, 1'b1);
        @(negedge clk);
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_rd_req", 128'(rd_req_o), 128'(0));
        chk("rst_rtrn_vld", 128'(rtrn_vld_o), 128'(0));
        chk("rst_ack", 128'(req_ack_o), 128'(0));
        chk("rst_rd_addr", 128'(rd_addr_o), 128'(0));
        chk("rst_rd_id", 128'(rd_id_o), 128'(0));
        chk("rst_rtrn_data", rtrn_data_o, 128'(0));
        chk("rst_rtrn_tid", 128'(rtrn_tid_o), 128'(0));
`ifdef ICACHE_REFILL_ERR_CHECK_EN
        chk("rst_err", 128'(err_o), 128'(0));
`endif
        step();

        // Back-to-back: valid held high; second ack the cycle after the return pulse.
        exp_rd.push_back('{addr: 64'h3000_0000, blen: 1'b1, id: 4'd4});
        exp_rtrn.push_back('{data: {64'hBB, 64'hAA}, tid: 4'd4});
        do_req(56'h3000_0000, 1'b0, 4'd4, 1'b1);
        req_paddr_i = 56'h3000_0148;
        req_tid_i   = 4'd5;
        exp_rd.push_back('{addr: 64'h3000_0140, blen: 1'b1, id: 4'd5});
        rtrn_cyc = -1;
        ack_cyc  = 99;
        fork
            begin
                grant(0);
                beat(64'hAA, 4'd4, 1'b0);
                beat(64'hBB, 4'd4, 1'b1);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (rtrn_vld_o) rtrn_cyc = i;
                    if (req_ack_o) begin
                        ack_cyc = i;
                        break;
                    end
                end
            end
        join
        chk("b2b_rtrn_seen", 128'(rtrn_cyc >= 0), 128'(1));
        chk("b2b_ack_cycle", 128'(ack_cyc), 128'(rtrn_cyc + 1));
        step();
        req_valid_i = 1'b0;
        exp_rtrn.push_back('{data: {64'hDD, 64'hCC}, tid: 4'd5});
        grant(0);
        beat(64'hCC, 4'd5, 1'b0);
        beat(64'hDD, 4'd5, 1'b1);
        repeat (3) step();

        chk("exp_rd_drained", 128'(exp_rd.size()), 128'(0));
        chk("exp_rtrn_drained", 128'(exp_rtrn.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_refill_assembler.md
# icache_refill_assembler

Refill-path stage between the L1 instruction cache memory interface and the AXI shim read port. It accepts one icache miss or bypass request at a time and holds the AXI read request until it is granted. It then collects the read beats by index into a full cache line and returns the line to the icache as a single-cycle valid pulse. It replaces ad-hoc shift-register buffering with an explicit FSM, beat counter, ID filter and flush-kill handling.

## Interface
- LineWidth, ICACHE_LINE_WIDTH (128): refill line width in bits
- DataWidth, 64: AXI beat width
- PlenWidth, riscv::PLEN (56): physical address width
- IdWidth, ariane_axi::IdWidth (4): AXI ID width; also icache TID width
- Derived: NumWords = LineWidth/DataWidth; BlenWidth = max(1, $clog2(NumWords))
- clk_i  in  1  clock
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- flush_i  in  1  kill any in-flight refill; its return is suppressed
- req_valid_i  in  1  icache memory request
- req_paddr_i  in  PlenWidth  request physical address
- req_nc_i  in  1  non-cacheable (single-beat) request
- req_tid_i  in  IdWidth  transaction ID
- req_ack_o  out  1  request accepted this cycle
- rd_req_o  out  1  AXI shim read request
- rd_gnt_i  in  1  AXI shim grant
- rd_addr_o  out  64  read address, zero-extended
- rd_blen_o  out  BlenWidth  burst length minus 1
- rd_size_o  out  2  constant 2'b11
- rd_id_o  out  IdWidth  latched TID
- rd_valid_i, rd_last_i  in  1  read beat valid / last
- rd_data_i  in  DataWidth  beat data
- rd_id_i  in  IdWidth  beat ID
- rd_exokay_i  in  1  exclusive-okay; used for error check only
- rtrn_vld_o  out  1  line return pulse
- rtrn_data_o  out  LineWidth  assembled line
- rtrn_tid_o  out  IdWidth  TID of the returned line
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky error flag; present only with the macro below

## Operation
- FSM states are IDLE, REQ, BURST and RTRN.
- IDLE:
  - req_ack_o = req_valid_i, combinational.
  - On ack, latch paddr/nc/tid, clear the line buffer and the beat counter, clear kill, and go to REQ.
- REQ:
  - rd_req_o=1. Address, blen and id are held stable until rd_gnt_i.
  - Cacheable: rd_addr_o = paddr with the low log2(LineWidth/8) bits cleared, and blen = NumWords-1.
  - nc: rd_addr_o = paddr unmodified, and blen = 0.
  - On rd_gnt_i go to BURST.
  - flush_i in REQ sets kill. The request is not withdrawn, because AXI requires it to stay asserted.
- BURST:
  - A beat is accepted when rd_valid_i and rd_id_i == latched tid. Mismatched-ID beats are ignored.
  - An accepted beat is written to word[cnt], and cnt increments, saturating at NumWords-1. The nc beat lands in word 0.
  - An accepted beat with rd_last_i goes to RTRN if kill is clear after this cycle's flush_i, otherwise to IDLE.
  - A short burst (last arrives before NumWords beats) returns the unwritten words as zero.
- RTRN:
  - rtrn_vld_o=1 for exactly one cycle, with rtrn_data_o and rtrn_tid_o from the registers.
  - Next state is IDLE.
  - flush_i in RTRN does not suppress the pulse already in progress.
- The beat counter is BlenWidth bits. For NumWords=2 it is a single bit.
- Beats arriving in IDLE, REQ or RTRN are dropped.

## Timing
- Reset values: all outputs 0, state IDLE, buffers zero, kill 0, err 0. req_ack_o is forced 0 while rst_i is high.
- Reset in any state returns to IDLE on the next edge. Late beats from the aborted burst are dropped.
- rd_req_o is registered. Request acked at cycle 0 gives rd_req_o high at cycle 1.
- Minimum gap from rd_gnt_i to the first beat is 1 cycle. A grant in the same cycle as rd_req_o first rises is legal.
- rtrn_vld_o rises the cycle after the accepted last beat.
- Best-case cacheable refill with 2 beats: ack@0, req@1, gnt@1, beats@2,3, rtrn@4.
- There is no back-pressure on rtrn_vld_o. The icache must sample it.

## Configuration
- ICACHE_REFILL_ERR_CHECK_EN defined:
  - err_o is present.
  - err_o sets sticky when either of these occurs in BURST:
    - an accepted beat has rd_exokay_i=0 while the lock bit is clear (i.e. any bus error is recorded as non-okay);
    - rd_valid_i with an ID mismatch.
  - err_o clears only on rst_i.
  - Additionally, a line whose burst saw an error is suppressed exactly like a kill.
- Undefined: err_o port omitted, errors ignored, no suppression.

## Structure
- Shared package (wt_cache_pkg) holds the FSM state enum, the NumWords/BlenWidth helper functions, and the refill request struct (paddr, nc, tid).
- One natural sub-module is icache_refill_linebuf: an indexed-write, clear-on-accept line register with a saturating counter.

## Test plan
- Cacheable: paddr 0x8000_1238, tid 3; grant after 2 cycles; beats 0xA, 0xB with last on 0xB -> rd_addr_o 0x8000_1230, blen 1; one rtrn_vld_o pulse with data {0xB,0xA}, tid 3.
- nc: paddr 0x1000_0004, single beat 0xDEAD with last -> rd_addr_o 0x1000_0004, blen 0; rtrn_data_o word0 = 0xDEAD, word1 = 0.
- ID filter: beat with id 5 during a tid-3 burst, then the two valid beats -> stray beat ignored, correct line returned; err_o=1 when the macro is on.
- flush_i during REQ, then a normal burst completes -> no rtrn_vld_o; busy_o drops after last; next request is acked the following cycle.
- rst_i after the first beat, then a late last beat arrives -> state IDLE, no return, all outputs 0.
- Back-to-back: req_valid_i held high through a refill -> second ack only in IDLE, the cycle after the rtrn_vld_o pulse.
